// File: rtl/collision_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : collision_pkg
// Brief    : Shared types and helpers for the multi-channel collision arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package collision_pkg;

    // Effective per-channel state, seen after any frame-boundary update
    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_FIRED    = 2'd1,
        ST_COOLDOWN = 2'd2
    } ch_state_e;

    // Width of a channel index covering n objects plus the background
    function automatic int ch_idx_w(input int n);
        return (n + 1 > 1) ? $clog2(n + 1) : 1;
    endfunction

    // The background channel always sits just above the object channels
    function automatic int bg_ch(input int n);
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/collision_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : collision_arbiter_if
// Brief    : Draw-request inputs and hit reporting outputs of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface collision_arbiter_if
    import collision_pkg::*;
#(
    parameter int NUM_OBJ = 4
);
    localparam int NCH  = NUM_OBJ + 1;
    localparam int ID_W = ch_idx_w(NUM_OBJ);

    logic                startOfFrame;
    logic                draw_request_player;
    logic [NUM_OBJ-1:0]  draw_request_obj;
    logic                draw_request_bg;
    logic                collision;
    logic [NCH-1:0]      hit_pulse;
    logic                SingleHitPulse;
    logic [NCH-1:0]      frame_hits;
    logic [ID_W-1:0]     first_hit_id;
    logic                first_hit_valid;

    // Pixel/frame source side
    modport master (
        output startOfFrame, draw_request_player, draw_request_obj, draw_request_bg,
        input  collision, hit_pulse, SingleHitPulse, frame_hits,
               first_hit_id, first_hit_valid
    );

    // Arbiter side
    modport slave (
        input  startOfFrame, draw_request_player, draw_request_obj, draw_request_bg,
        output collision, hit_pulse, SingleHitPulse, frame_hits,
               first_hit_id, first_hit_valid
    );
endinterface
`default_nettype wire

// File: rtl/collision_arbiter_channel.sv
`default_nettype none
// ============================================================================
// Module   : collision_channel
// Brief    : One hit channel: fired-this-frame flag, frame cooldown counter,
//            hit qualification and the registered hit pulse.
// Revision : 1.0 - initial release
// ============================================================================
module collision_channel
    import collision_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 0,
    parameter int CD_W            = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic sof_i,
    input  wire logic player_i,
    input  wire logic req_i,
    output logic      qual_o,
    output logic      hit_pulse_o
);
    logic            fired_q, fired_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            hit_q;
    logic            fired_eff;
    logic [CD_W-1:0] cd_eff;
    ch_state_e       state_eff;
    logic            qual;

    // Frame-boundary view of the state, qualification and next state.
    // The frame boundary right after a fire does not decrement the counter:
    // the fire frame is the FIRED state, and the COOLDOWN_FRAMES masked
    // frames start with the following frame.
    always_comb begin
        fired_eff = fired_q;
        cd_eff    = cd_q;
        state_eff = ST_ARMED;
        if (sof_i) begin
            fired_eff = 1'b0;
            if (!fired_q && (cd_q != '0))
                cd_eff = cd_q - 1'b1;
        end
        if (fired_eff)
            state_eff = ST_FIRED;
        else if (cd_eff != '0)
            state_eff = ST_COOLDOWN;
        qual    = player_i && req_i && (state_eff == ST_ARMED);
        fired_d = fired_eff;
        cd_d    = cd_eff;
        if (qual) begin
            fired_d = 1'b1;
            cd_d    = CD_W'(COOLDOWN_FRAMES);
        end
    end

    // Channel state and hit pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fired_q <= 1'b0;
            cd_q    <= '0;
            hit_q   <= 1'b0;
        end else begin
            fired_q <= fired_d;
            cd_q    <= cd_d;
            hit_q   <= qual;
        end
    end

    assign qual_o      = qual;
    assign hit_pulse_o = hit_q;

endmodule
`default_nettype wire

// File: rtl/collision_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : collision_arbiter
// Brief    : Qualifies player overlap against NUM_OBJ object channels plus a
//            background channel; per-channel pulses, per-frame summary.
// Revision : 1.0 - initial release
// ============================================================================
module collision_arbiter
    import collision_pkg::*;
#(
    parameter int NUM_OBJ         = 4,
    parameter int COOLDOWN_FRAMES = 0,
    parameter int CD_W            = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    collision_arbiter_if.slave bus
);
    localparam int NCH   = NUM_OBJ + 1;
    localparam int ID_W  = ch_idx_w(NUM_OBJ);
    localparam int BG_CH = bg_ch(NUM_OBJ);

    logic [NCH-1:0]  req;
    logic [NCH-1:0]  qual;
    logic [NCH-1:0]  hit_vec;
    logic            any_qual;
    logic            frame_any_eff;

    logic            single_q, single_d;
    logic [NCH-1:0]  acc_q, acc_d;
    logic [NCH-1:0]  frame_hits_q, frame_hits_d;
    logic [ID_W-1:0] first_id_q, first_id_d;
    logic            first_valid_q, first_valid_d;

    // Lowest-index set bit wins
    function automatic logic [ID_W-1:0] lowest_set(input logic [NCH-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (v[i]) idx = ID_W'(i);
        return idx;
    endfunction

    assign req[NUM_OBJ-1:0] = bus.draw_request_obj;
    assign req[BG_CH]       = bus.draw_request_bg;

    assign bus.collision = bus.draw_request_player &&
                           ((|bus.draw_request_obj) || bus.draw_request_bg);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            collision_channel #(
                .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
                .CD_W            (CD_W)
            ) u_ch (
                .clk         (clk),
                .reset       (reset),
                .sof_i       (bus.startOfFrame),
                .player_i    (bus.draw_request_player),
                .req_i       (req[gi]),
                .qual_o      (qual[gi]),
                .hit_pulse_o (hit_vec[gi])
            );
        end
    endgenerate

    assign any_qual = |qual;
    // A valid first hit means something already fired in this frame
    assign frame_any_eff = bus.startOfFrame ? 1'b0 : first_valid_q;

    // Frame summary next state; a hit on the boundary cycle is new-frame only
    always_comb begin
        single_d      = any_qual && !frame_any_eff;
        acc_d         = acc_q | qual;
        frame_hits_d  = frame_hits_q;
        first_id_d    = first_id_q;
        first_valid_d = first_valid_q;
        if (bus.startOfFrame) begin
            acc_d         = qual;
            frame_hits_d  = acc_q;
            first_id_d    = '0;
            first_valid_d = 1'b0;
        end
        if (any_qual && !frame_any_eff) begin
            first_id_d    = lowest_set(qual);
            first_valid_d = 1'b1;
        end
    end

    // Frame summary registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            single_q      <= 1'b0;
            acc_q         <= '0;
            frame_hits_q  <= '0;
            first_id_q    <= '0;
            first_valid_q <= 1'b0;
        end else begin
            single_q      <= single_d;
            acc_q         <= acc_d;
            frame_hits_q  <= frame_hits_d;
            first_id_q    <= first_id_d;
            first_valid_q <= first_valid_d;
        end
    end

    assign bus.hit_pulse       = hit_vec;
    assign bus.SingleHitPulse  = single_q;
    assign bus.frame_hits      = frame_hits_q;
    assign bus.first_hit_id    = first_id_q;
    assign bus.first_hit_valid = first_valid_q;

endmodule
`default_nettype wire
